// File: rtl/nv_fifo_ctrl_128x14_pkg.sv
// Shared FIFO geometry for the 128x14 controller family.
// Depth, pointer, count and data widths live here.
package nv_fifo_ctrl_128x14_pkg;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int CW    = 8;
  localparam int DW    = 14;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_128x14.sv
// 128x14 RAM: one write port, registered read address and read data.
// re latches ra into ra_d; ore latches mem[ra_d] into the output register.
module nv_ram_rwsp_128x14
  import nv_fifo_ctrl_128x14_pkg::*;
(
  input  logic          clk,
  input  logic [31:0]   pwrbus_ram_pd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  input  logic          ore,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] di,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_d;
  logic          unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_d <= ra;
    if (ore) dout <= mem[ra_d];
  end

endmodule

// File: rtl/nv_fifo_ctrl_128x14.sv
// 128x14 valid/ready FIFO controller.
// Sequences a 2-stage-read RAM; slots free only on pop.
module nv_fifo_ctrl_128x14
  import nv_fifo_ctrl_128x14_pkg::*;
#(
  parameter int unsigned ALMOST_FULL_THR = 120
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          wr_almost_full,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [CW-1:0] occupancy,
  output logic          idle,
  input  logic [31:0]   pwrbus_ram_pd
);

  localparam logic [CW-1:0] AF_THR =
    CW'(ALMOST_FULL_THR);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] rd_avail;
  logic [CW-1:0] occ_nxt;
  logic [CW-1:0] avail_nxt;
  logic          a_vld;
  logic          b_vld;
  logic          push;
  logic          pop;
  logic          re;
  logic          ore;

  always_comb begin
    push      = wr_pvld && wr_prdy;
    pop       = b_vld && rd_prdy;
    ore       = a_vld && (!b_vld || rd_prdy);
    re        = (rd_avail != '0) && (!a_vld || ore);
    occ_nxt   = occupancy + CW'(push) - CW'(pop);
    avail_nxt = rd_avail + CW'(push) - CW'(re);
  end

  assign rd_pvld = b_vld;
  assign idle    = (occupancy == '0) && !a_vld && !b_vld;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_avail       <= '0;
      occupancy      <= '0;
      a_vld          <= 1'b0;
      b_vld          <= 1'b0;
      wr_prdy        <= 1'b0;
      wr_almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (re) rd_ptr <= ptr_inc(rd_ptr);
      rd_avail       <= avail_nxt;
      occupancy      <= occ_nxt;
      a_vld          <= re | (a_vld & !ore);
      b_vld          <= ore | (b_vld & !rd_prdy);
      wr_prdy        <= occ_nxt < FULL_CNT;
      wr_almost_full <= occ_nxt >= AF_THR;
    end
  end

  nv_ram_rwsp_128x14 ram (
    .clk           (nvdla_core_clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .re            (re),
    .ra            (rd_ptr),
    .ore           (ore),
    .we            (push),
    .wa            (wr_ptr),
    .di            (wr_pd),
    .dout          (rd_pd)
  );

endmodule

// File: tb/tb_nv_fifo_ctrl_128x14.sv
// Self-checking bench for nv_fifo_ctrl_128x14.
// Reference model: an ordered queue of accepted words.
module tb_nv_fifo_ctrl_128x14;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [13:0] wr_pd;
  logic        wr_almost_full;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [13:0] rd_pd;
  logic [7:0]  occupancy;
  logic        idle;
  logic [31:0] pwrbus_ram_pd;

  int          n_err = 0;
  int          n_chk = 0;
  logic [13:0] q[$];
  int          npush = 0;
  int          npop = 0;
  int          exp_pvld = -1;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_pd = '0;
  logic [13:0] last_pop = '0;

  always #5 clk = ~clk;

  nv_fifo_ctrl_128x14 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .wr_almost_full  (wr_almost_full),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .occupancy       (occupancy),
    .idle            (idle),
    .pwrbus_ram_pd   (pwrbus_ram_pd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock cycle: check at negedge, update model, return at posedge+1.
  task automatic cyc();
    logic full;
    @(negedge clk);
    full = q.size() >= 128;
    if (prev_stall) begin
      chk("stall_vld", rd_pvld, 1);
      chk("stall_pd", rd_pd, prev_pd);
    end
    if (exp_pvld >= 0) begin
      chk("pvld_lat", rd_pvld, exp_pvld);
      exp_pvld = -1;
    end
    chk("occupancy", occupancy, q.size());
    chk("wr_prdy", wr_prdy, !full);
    chk("almost_full", wr_almost_full, q.size() >= 120);
    chk("idle", idle, q.size() == 0);
    if (rd_pvld && rd_prdy) begin
      chk("pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        last_pop = q.pop_front();
        chk("pop_data", rd_pd, last_pop);
      end
      npop++;
    end
    prev_stall = rd_pvld && !rd_prdy;
    prev_pd = rd_pd;
    if (wr_pvld && !full) begin
      q.push_back(wr_pd);
      npush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    while (q.size() != 0 && n < 600) begin
      cyc();
      n++;
    end
    chk("drain_left", q.size(), 0);
    cyc();
  endtask

  initial begin
    int np0;
    int cnt;
    int start;
    rstn = 1'b0;
    wr_pvld = 1'b0;
    wr_pd = '0;
    rd_prdy = 1'b0;
    pwrbus_ram_pd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_prdy", wr_prdy, 0);
    chk("rst_af", wr_almost_full, 0);
    chk("rst_pvld", rd_pvld, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk);
    #1;

    // single word latency
    wr_pvld = 1'b1;
    wr_pd = 14'h2A5D;
    rd_prdy = 1'b1;
    exp_pvld = 0;
    cyc();
    wr_pvld = 1'b0;
    exp_pvld = 0;
    cyc();
    exp_pvld = 0;
    cyc();
    exp_pvld = 1;
    cyc();
    chk("lat_data", last_pop, 14'h2A5D);
    exp_pvld = 0;
    cyc();

    // fill to full
    rd_prdy = 1'b0;
    wr_pvld = 1'b1;
    for (int i = 0; i < 128; i++) begin
      wr_pd = 14'(i);
      cyc();
    end
    chk("full_occ", occupancy, 128);
    chk("full_prdy", wr_prdy, 0);
    chk("full_af", wr_almost_full, 1);
    wr_pd = 14'h3FFF;
    exp_pvld = 1;
    cyc();
    rd_prdy = 1'b1;
    cyc();
    rd_prdy = 1'b0;
    chk("refill_prdy", wr_prdy, 1);
    cyc();
    drain();
    chk("last_pop", last_pop, 14'h3FFF);

    // continuous streaming
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    np0 = npop;
    for (int c = 0; c < 300; c++) begin
      wr_pd = 14'(c + 5);
      if (c == 10) np0 = npop;
      if (c == 150) chk("steady_occ", occupancy, 3);
      cyc();
    end
    chk("throughput", npop - np0, 290);
    drain();

    // random traffic
    start = npush;
    cnt = 0;
    while ((npush - start < 2000 || q.size() != 0)
           && cnt < 20000) begin
      wr_pvld = (npush - start < 2000) &&
                ($urandom_range(0, 99) >= 30);
      wr_pd = 14'($urandom);
      rd_prdy = $urandom_range(0, 99) >= 30;
      cyc();
      cnt++;
    end
    chk("rand_pushed", npush - start, 2000);
    chk("rand_left", q.size(), 0);
    drain();

    // reset mid-stream
    rd_prdy = 1'b0;
    wr_pvld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wr_pd = 14'($urandom);
      cyc();
    end
    chk("pre_rst_occ", occupancy, 50);
    rstn = 1'b0;
    #1;
    chk("mid_rst_pvld", rd_pvld, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_prdy", wr_prdy, 0);
    chk("mid_rst_idle", idle, 1);
    q.delete();
    prev_stall = 1'b0;
    wr_pvld = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_prdy0", wr_prdy, 0);
    @(posedge clk);
    #1;
    chk("rel_prdy1", wr_prdy, 1);
    rd_prdy = 1'b1;
    wr_pvld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_pd = 14'(14'h1000 + i);
      cyc();
    end
    drain();
    chk("post_rst_last", last_pop, 14'h1013);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
